// File: rtl/rx_mem_wr_arbiter_pkg.sv
// Shared definitions for the RX packet-memory write arbiter.
//   switch_pkg : port count and port index type.
//   rx_tx_pkg  : beat width, frame limits, length type, arbiter state encoding.
package switch_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [PORT_W-1:0] port_t;
endpackage

package rx_tx_pkg;
  localparam int DATA_WIDTH      = 8;
  localparam int MAX_FRAME_BYTES = 1522;
  localparam int TIMEOUT_CYCLES  = 64;
  localparam int LEN_W           = $clog2(MAX_FRAME_BYTES + 1);
  typedef logic [LEN_W-1:0] len_t;
  typedef enum logic [1:0] {IDLE, GRANT, DROP, DONE} arb_state_e;
endpackage

// File: rtl/rx_mem_wr_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted requester
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  // Walk from the lowest priority to the highest so the last hit wins:
  // that is the first requester at or after ptr, wrapping.
  always_comb begin : pick
    logic [IDX_W:0]   s;
    logic [IDX_W-1:0] p;
    gnt = '0;
    idx = '0;
    s   = '0;
    p   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (s >= (IDX_W + 1)'(N)) s = s - (IDX_W + 1)'(N);
      p = s[IDX_W-1:0];
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end
endmodule

// File: rtl/rx_mem_wr_arbiter.sv
// Frame-granular round-robin scheduler for the single packet-memory write port.
// A granted RX port owns the write port from SOF to EOF; each granted frame ends
// in exactly one commit or drop pulse. Errored, oversize and stalled frames are
// aborted (memory rolls back its write pointer on mem_wr_abort_o).
// Ports:
//   switch_clk / switch_rst_n          clock, async active-low reset
//   rx_valid_i/data/sof/eof/err_i[P]   per-port head beat
//   rx_ready_o[P]                      pop head beat of port P
//   mem_wr_valid/data/sof/eof_o        write beat to memory, mem_wr_ready_i accepts
//   mem_wr_abort_o                     discard the partial frame in memory
//   frame_commit_o / frame_drop_o      per-frame status, with frame_port_o / frame_len_o
//   orphan_cnt_o                       saturating count of flushed non-SOF head beats
module rx_mem_wr_arbiter #(
  parameter int  NUM_PORTS       = switch_pkg::NUM_PORTS,
  parameter int  DATA_WIDTH      = rx_tx_pkg::DATA_WIDTH,
  parameter int  MAX_FRAME_BYTES = rx_tx_pkg::MAX_FRAME_BYTES,
  parameter int  TIMEOUT_CYCLES  = rx_tx_pkg::TIMEOUT_CYCLES,
  localparam int PORT_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int LEN_W           = $clog2(MAX_FRAME_BYTES + 1)
) (
  input  logic                                 switch_clk,
  input  logic                                 switch_rst_n,
  input  logic [NUM_PORTS-1:0]                 rx_valid_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rx_data_i,
  input  logic [NUM_PORTS-1:0]                 rx_sof_i,
  input  logic [NUM_PORTS-1:0]                 rx_eof_i,
  input  logic [NUM_PORTS-1:0]                 rx_err_i,
  output logic [NUM_PORTS-1:0]                 rx_ready_o,
  output logic                                 mem_wr_valid_o,
  output logic [DATA_WIDTH-1:0]                mem_wr_data_o,
  output logic                                 mem_wr_sof_o,
  output logic                                 mem_wr_eof_o,
  input  logic                                 mem_wr_ready_i,
  output logic                                 mem_wr_abort_o,
  output logic                                 frame_commit_o,
  output logic                                 frame_drop_o,
  output logic [PORT_W-1:0]                    frame_port_o,
  output logic [LEN_W-1:0]                     frame_len_o,
  output logic [15:0]                          orphan_cnt_o
);
  import rx_tx_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e        state_q, state_d;
  logic [PORT_W-1:0] gnt_q, gnt_d, rr_q, rr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic              drop_q, drop_d;
  logic [15:0]       orphan_q;

  logic [NUM_PORTS-1:0] arb_gnt, flush;
  logic [PORT_W-1:0]    arb_idx;
  logic                 own, timeout;
  logic                 g_valid, g_sof, g_eof, g_err;
  logic [DATA_WIDTH-1:0] g_data;
  logic [16:0]          orphan_sum;

  rr_arbiter #(.N(NUM_PORTS), .IDX_W(PORT_W)) u_rr (
    .req (rx_valid_i & rx_sof_i),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Head beat of the granted port.
  assign g_valid = rx_valid_i[gnt_q];
  assign g_data  = rx_data_i[gnt_q];
  assign g_sof   = rx_sof_i[gnt_q];
  assign g_eof   = rx_eof_i[gnt_q];
  assign g_err   = rx_err_i[gnt_q];

  // The granted port is only "owned" while its frame is being written or drained;
  // in DONE its head is already the next frame (or stray bytes to flush).
  assign own     = (state_q == GRANT) || (state_q == DROP);
  assign timeout = !g_valid && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Non-SOF beats at the head of a port nobody owns can never start a frame:
  // pop them. Gated by reset so every output is low while reset is held.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_flush
    assign flush[p] = switch_rst_n & rx_valid_i[p] & ~rx_sof_i[p] &
                      ~(own & (gnt_q == PORT_W'(p)));
  end

  assign orphan_sum   = {1'b0, orphan_q} + 17'($countones(flush));
  assign orphan_cnt_o = orphan_q;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_d           = rr_q;
    len_d          = len_q;
    drop_d         = drop_q;
    idle_d         = g_valid ? '0 : idle_q + 1'b1;
    rx_ready_o     = flush;
    mem_wr_valid_o = 1'b0;
    mem_wr_data_o  = '0;
    mem_wr_sof_o   = 1'b0;
    mem_wr_eof_o   = 1'b0;
    mem_wr_abort_o = 1'b0;
    frame_commit_o = 1'b0;
    frame_drop_o   = 1'b0;
    frame_port_o   = '0;
    frame_len_o    = '0;
    case (state_q)
      IDLE: begin
        idle_d = '0;
        len_d  = '0;
        drop_d = 1'b0;
        if (|arb_gnt) begin
          gnt_d   = arb_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        mem_wr_data_o = g_data;
        mem_wr_sof_o  = g_sof;
        mem_wr_eof_o  = g_eof;
        if (g_valid && g_err) begin
          // Errored beat is swallowed, never written.
          rx_ready_o[gnt_q] = 1'b1;
          mem_wr_abort_o    = 1'b1;
          drop_d            = 1'b1;
          state_d           = g_eof ? DONE : DROP;
        end else begin
          mem_wr_valid_o    = g_valid;
          rx_ready_o[gnt_q] = mem_wr_ready_i;
          if (g_valid && mem_wr_ready_i) begin
            len_d = len_q + 1'b1;
            if (g_eof) begin
              state_d = DONE;
            end else if (len_q == LEN_W'(MAX_FRAME_BYTES - 1)) begin
              // Frame hit the size limit and still has more bytes.
              mem_wr_abort_o = 1'b1;
              drop_d         = 1'b1;
              state_d        = DROP;
            end
          end else if (timeout) begin
            mem_wr_abort_o = 1'b1;
            drop_d         = 1'b1;
            state_d        = DONE;
          end
        end
      end
      DROP: begin
        rx_ready_o[gnt_q] = 1'b1;
        if ((g_valid && g_eof) || timeout) state_d = DONE;
      end
      DONE: begin
        frame_commit_o = ~drop_q;
        frame_drop_o   = drop_q;
        frame_port_o   = gnt_q;
        frame_len_o    = len_q;
        rr_d           = (gnt_q == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      len_q    <= '0;
      idle_q   <= '0;
      drop_q   <= 1'b0;
      orphan_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      len_q    <= len_d;
      idle_q   <= idle_d;
      drop_q   <= drop_d;
      orphan_q <= orphan_sum[16] ? 16'hFFFF : orphan_sum[15:0];
    end
  end
endmodule

// File: tb/tb_rx_mem_wr_arbiter.sv
// Randomized bench for rx_mem_wr_arbiter: per-port beat sources, a frame-level
// reference model compared against every output each cycle, and directed
// scenarios with hand-computed expectations.
module tb_rx_mem_wr_arbiter;
  localparam int NP = 4, DW = 8, MAXB = 1522, TMO = 64, PW = 2, LW = 11, QD = 4096;

  logic switch_clk = 1'b0;
  logic switch_rst_n = 1'b0;
  logic [NP-1:0] rx_valid = '0;
  logic [NP-1:0] rx_sof = '0;
  logic [NP-1:0] rx_eof = '0;
  logic [NP-1:0] rx_err = '0;
  logic [NP-1:0][DW-1:0] rx_data = '0;
  logic [NP-1:0] rx_ready;
  logic mem_rdy = 1'b0;
  logic mem_wr_valid, mem_wr_sof, mem_wr_eof, mem_wr_abort, frame_commit, frame_drop;
  logic [DW-1:0] mem_wr_data;
  logic [PW-1:0] frame_port;
  logic [LW-1:0] frame_len;
  logic [15:0] orphan_cnt;

  rx_mem_wr_arbiter dut (
    .switch_clk(switch_clk), .switch_rst_n(switch_rst_n),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_sof_i(rx_sof),
    .rx_eof_i(rx_eof), .rx_err_i(rx_err), .rx_ready_o(rx_ready),
    .mem_wr_valid_o(mem_wr_valid), .mem_wr_data_o(mem_wr_data),
    .mem_wr_sof_o(mem_wr_sof), .mem_wr_eof_o(mem_wr_eof),
    .mem_wr_ready_i(mem_rdy), .mem_wr_abort_o(mem_wr_abort),
    .frame_commit_o(frame_commit), .frame_drop_o(frame_drop),
    .frame_port_o(frame_port), .frame_len_o(frame_len),
    .orphan_cnt_o(orphan_cnt)
  );

  always #5 switch_clk = ~switch_clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  int vprob = 100, rprob = 100;

  // Beat sources: {err, eof, sof, data}
  logic [10:0] smem [NP][QD];
  int  wp [NP];
  int  rp [NP];
  bit  hold [NP];

  // Reference model: who owns the write port and what it is doing with the frame.
  int m_owner, m_report, m_rr, m_len, m_idle, m_orph;   // m_report: 0 none, 1 commit, 2 drop
  bit m_fwd, m_disc;
  int n_owner, n_report, n_rr, n_len, n_idle, n_orph;
  bit n_fwd, n_disc;
  logic [NP-1:0] e_ready;
  logic [DW-1:0] e_data;
  bit e_valid, e_sof, e_eof, e_abort, e_commit, e_drop;
  int e_port, e_len;

  // Observations of the DUT for the directed expectations.
  int beats, first_req, first_sof, n_commit, n_drop, n_abort, c_port, c_len, d_port, d_len;
  int seq[$];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [10:0] b);
    if (wp[p] >= QD) begin
      $display("FAIL source_overflow port=%0d got=%0d expected<%0d", p, wp[p], QD);
      $fatal(1);
    end
    smem[p][wp[p]] = b;
    wp[p]++;
  endtask

  task automatic add_frame(input int p, input int len, input int err_at);
    for (int i = 1; i <= len; i++)
      push(p, {(i == err_at), (i == len), (i == 1), 8'($urandom)});
  endtask

  task automatic model_reset();
    m_owner = 0; m_report = 0; m_rr = 0; m_len = 0; m_idle = 0; m_orph = 0;
    m_fwd = 0; m_disc = 0;
  endtask

  task automatic model_eval();
    int o;
    bit ov, found;
    o = m_owner;
    ov = (m_fwd || m_disc) ? rx_valid[o] : 1'b0;
    e_ready = '0; e_valid = 0; e_data = '0; e_sof = 0; e_eof = 0; e_abort = 0;
    e_commit = 0; e_drop = 0; e_port = 0; e_len = 0;
    n_owner = m_owner; n_report = 0; n_rr = m_rr; n_len = m_len; n_idle = m_idle;
    n_orph = m_orph; n_fwd = m_fwd; n_disc = m_disc;
    if (m_report != 0) begin
      e_commit = (m_report == 1); e_drop = (m_report == 2);
      e_port = m_owner; e_len = m_len;
      n_rr = (m_owner + 1) % NP;
    end else if (m_fwd) begin
      e_data = rx_data[o]; e_sof = rx_sof[o]; e_eof = rx_eof[o];
      n_idle = ov ? 0 : m_idle + 1;
      if (ov && rx_err[o]) begin
        e_ready[o] = 1; e_abort = 1; n_fwd = 0;
        if (rx_eof[o]) n_report = 2; else n_disc = 1;
      end else begin
        e_valid = ov; e_ready[o] = mem_rdy;
        if (ov && mem_rdy) begin
          n_len = m_len + 1;
          if (rx_eof[o]) begin n_fwd = 0; n_report = 1; end
          else if (n_len == MAXB) begin e_abort = 1; n_fwd = 0; n_disc = 1; end
        end else if (n_idle == TMO) begin
          e_abort = 1; n_fwd = 0; n_report = 2;
        end
      end
    end else if (m_disc) begin
      e_ready[o] = 1;
      n_idle = ov ? 0 : m_idle + 1;
      if ((ov && rx_eof[o]) || n_idle == TMO) begin n_disc = 0; n_report = 2; end
    end else begin
      n_len = 0; n_idle = 0; found = 0;
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_rr + k) % NP;
        if (!found && rx_valid[p] && rx_sof[p]) begin found = 1; n_owner = p; n_fwd = 1; end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (!((m_fwd || m_disc) && p == m_owner) && rx_valid[p] && !rx_sof[p]) begin
        e_ready[p] = 1;
        if (n_orph < 65535) n_orph++;
      end
    end
  endtask

  task automatic compare_all();
    chk("rx_ready", int'(rx_ready), int'(e_ready));
    chk("wr_valid", int'(mem_wr_valid), int'(e_valid));
    chk("wr_data", int'(mem_wr_data), int'(e_data));
    chk("wr_sof", int'(mem_wr_sof), int'(e_sof));
    chk("wr_eof", int'(mem_wr_eof), int'(e_eof));
    chk("wr_abort", int'(mem_wr_abort), int'(e_abort));
    chk("commit", int'(frame_commit), int'(e_commit));
    chk("drop", int'(frame_drop), int'(e_drop));
    chk("frame_port", int'(frame_port), e_port);
    chk("frame_len", int'(frame_len), e_len);
    chk("orphan_cnt", int'(orphan_cnt), m_orph);
  endtask

  task automatic observe();
    if (first_req < 0 && rx_valid != '0) first_req = cyc;
    if (mem_wr_valid && mem_rdy) begin
      beats++;
      if (mem_wr_sof && first_sof < 0) first_sof = cyc;
    end
    if (frame_commit) begin n_commit++; c_port = int'(frame_port); c_len = int'(frame_len); seq.push_back(int'(frame_port)); end
    if (frame_drop) begin n_drop++; d_port = int'(frame_port); d_len = int'(frame_len); end
    if (mem_wr_abort) n_abort++;
  endtask

  task automatic clear_obs();
    beats = 0; first_req = -1; first_sof = -1; n_commit = 0; n_drop = 0; n_abort = 0;
    c_port = -1; c_len = -1; d_port = -1; d_len = -1;
    seq.delete();
  endtask

  task automatic drive();
    logic [10:0] b;
    for (int p = 0; p < NP; p++) begin
      if (!hold[p] && rp[p] < wp[p] && int'($urandom_range(99)) < vprob) hold[p] = 1;
      if (hold[p]) begin
        b = smem[p][rp[p]];
        rx_valid[p] = 1; rx_data[p] = b[7:0]; rx_sof[p] = b[8]; rx_eof[p] = b[9]; rx_err[p] = b[10];
      end else begin
        rx_valid[p] = 0; rx_data[p] = 8'($urandom); rx_sof[p] = 0; rx_eof[p] = 0; rx_err[p] = 0;
      end
    end
    mem_rdy = (int'($urandom_range(99)) < rprob);
  endtask

  task automatic step();
    @(negedge switch_clk);
    model_eval();
    compare_all();
    observe();
    @(posedge switch_clk);
    #1;
    for (int p = 0; p < NP; p++)
      if (e_ready[p] && rx_valid[p]) begin rp[p]++; hold[p] = 0; end
    m_owner = n_owner; m_report = n_report; m_rr = n_rr; m_len = n_len;
    m_idle = n_idle; m_orph = n_orph; m_fwd = n_fwd; m_disc = n_disc;
    cyc++;
    drive();
  endtask

  function automatic bit pending();
    for (int p = 0; p < NP; p++) if (rp[p] < wp[p] || hold[p]) return 1;
    return m_fwd || m_disc || (m_report != 0);
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin step(); n++; end
    if (n >= budget) chk("run_budget", n, budget - 1);
    step(); step();
  endtask

  task automatic do_reset();
    switch_rst_n = 0;
    for (int p = 0; p < NP; p++) begin rp[p] = 0; wp[p] = 0; hold[p] = 0; end
    rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_err = '0; rx_data = '0; mem_rdy = 0;
    model_reset();
    repeat (2) @(posedge switch_clk);
    @(negedge switch_clk);
    model_eval();
    compare_all();
    @(posedge switch_clk);
    #1;
    switch_rst_n = 1;
    drive();
    clear_obs();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    clear_obs();
    do_reset();

    // 64-byte frame on port 0, no backpressure.
    vprob = 100; rprob = 100;
    add_frame(0, 64, 0);
    run_until_idle(500);
    chk("t1_arb_latency", first_sof - first_req, 1);
    chk("t1_commits", n_commit, 1);
    chk("t1_port", c_port, 0);
    chk("t1_len", c_len, 64);
    chk("t1_beats", beats, 64);

    // rr pointer now past port 0: port 1 wins a tie.
    clear_obs();
    add_frame(0, 10, 0);
    add_frame(1, 10, 0);
    run_until_idle(500);
    chk("t1_rr_n", seq.size(), 2);
    if (seq.size() == 2) begin
      chk("t1_rr_first", seq[0], 1);
      chk("t1_rr_second", seq[1], 0);
    end

    // All ports request together, port 0 has a second frame queued.
    do_reset();
    add_frame(0, 20, 0);
    add_frame(0, 20, 0);
    for (int p = 1; p < NP; p++) add_frame(p, 20, 0);
    run_until_idle(1000);
    chk("t2_n", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk($sformatf("t2_order%0d", i), seq[i], exp_order[i]);

    // Memory backpressure mid-frame.
    clear_obs();
    rprob = 50;
    add_frame(1, 40, 0);
    run_until_idle(1000);
    chk("t3_len", c_len, 40);
    chk("t3_beats", beats, 40);
    rprob = 100;

    // Error on byte 30 of a 70-byte frame, then a good frame.
    clear_obs();
    add_frame(2, 70, 30);
    add_frame(2, 20, 0);
    run_until_idle(1000);
    chk("t4_aborts", n_abort, 1);
    chk("t4_drop_port", d_port, 2);
    chk("t4_drop_len", d_len, 29);
    chk("t4_commit_len", c_len, 20);
    chk("t4_beats", beats, 49);

    // Oversize frame.
    clear_obs();
    add_frame(3, 1600, 0);
    run_until_idle(3000);
    chk("t5_aborts", n_abort, 1);
    chk("t5_drop_len", d_len, MAXB);
    chk("t5_beats", beats, MAXB);
    chk("t5_commits", n_commit, 0);

    // Port stalls mid-frame after 10 bytes, later 5 stray bytes arrive.
    do_reset();
    for (int i = 1; i <= 10; i++) push(0, {1'b0, 1'b0, (i == 1), 8'(i)});
    run_until_idle(500);
    chk("t6_drops", n_drop, 1);
    chk("t6_aborts", n_abort, 1);
    chk("t6_drop_port", d_port, 0);
    chk("t6_drop_len", d_len, 10);
    for (int i = 0; i < 5; i++) push(0, {3'b000, 8'(i)});
    run_until_idle(500);
    chk("t6_orphans", int'(orphan_cnt), 5);

    // Random traffic across all ports, two pressure profiles.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      vprob = (r == 0) ? 100 : 50;
      rprob = (r == 0) ? 40 : 90;
      for (int i = 0; i < 120; i++) begin
        int p, len, err_at;
        p = int'($urandom_range(NP - 1));
        if ($urandom_range(99) < 6)
          for (int j = 0; j <= int'($urandom_range(2)); j++) push(p, {3'b000, 8'($urandom)});
        len = ($urandom_range(9) == 0) ? 1 : int'($urandom_range(40, 2));
        err_at = ($urandom_range(9) == 0) ? int'($urandom_range(len, 1)) : 0;
        add_frame(p, len, err_at);
      end
      run_until_idle(30000);
    end

    // Reset asserted while a frame is being written.
    do_reset();
    vprob = 100; rprob = 100;
    add_frame(1, 50, 0);
    repeat (20) step();
    chk("rst_pre_valid", int'(mem_wr_valid), 1);
    #2;
    switch_rst_n = 0;
    #1;
    chk("rst_valid", int'(mem_wr_valid), 0);
    chk("rst_ready", int'(rx_ready), 0);
    chk("rst_abort", int'(mem_wr_abort), 0);
    chk("rst_status", int'(frame_commit) + int'(frame_drop), 0);
    chk("rst_orphan", int'(orphan_cnt), 0);
    do_reset();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
